// File: rtl/stopwatch_pkg.sv
// Shared types for the stopwatch command sequencer: FSM states, button-event priority.
// STOPWATCH_LAP_EN adds the SPLIT state; without it the encoding holds IDLE/RUN/PAUSE only.
package stopwatch_pkg;

  localparam int DEBOUNCE_DEFAULT = 20;
  localparam int DEBOUNCE_CNT_W   = 8;

`ifdef STOPWATCH_LAP_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_SPLIT = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_e;
`endif

  typedef enum logic [2:0] {
    EV_NONE       = 3'd0,
    EV_LAP        = 3'd1,
    EV_START_STOP = 3'd2,
    EV_MAX        = 3'd3,
    EV_CLEAR      = 3'd4
  } event_e;

  // Only the highest-priority event in a cycle acts; the rest are dropped.
  function automatic event_e pickEvent(input logic clearEv,
                                       input logic maxEv,
                                       input logic startStopEv,
                                       input logic lapEv);
    if (clearEv)          return EV_CLEAR;
    else if (maxEv)       return EV_MAX;
    else if (startStopEv) return EV_START_STOP;
    else if (lapEv)       return EV_LAP;
    else                  return EV_NONE;
  endfunction

endpackage

// File: rtl/stopwatch_button_conditioner.sv
// Push-button conditioner: 2-flop synchroniser, tick-paced debouncer, rising-edge press pulse.
// Unaffected by STOPWATCH_LAP_EN; the top decides how many instances exist.
module button_conditioner
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEBOUNCE_DEFAULT
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_tick,
  input  logic i_btn,
  output logic o_press
);

  localparam logic [DEBOUNCE_CNT_W-1:0] LAST_TICK = DEBOUNCE_CNT_W'(DEBOUNCE_TICKS - 1);

  logic [1:0]                r_sync;
  logic [DEBOUNCE_CNT_W-1:0] r_count;
  logic                      r_stable;
  logic                      r_stablePrev;
  logic                      r_press;

  // The counter only advances while the synchronised level disagrees with the
  // debounced one, so any glitch back to the old level restarts the count.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync       <= '0;
      r_count      <= '0;
      r_stable     <= 1'b0;
      r_stablePrev <= 1'b0;
      r_press      <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      if (r_sync[1] == r_stable) begin
        r_count <= '0;
      end else if (i_tick) begin
        if (r_count == LAST_TICK) begin
          r_stable <= r_sync[1];
          r_count  <= '0;
        end else begin
          r_count <= r_count + 1'b1;
        end
      end
      r_stablePrev <= r_stable;
      r_press      <= r_stable & ~r_stablePrev;
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch command sequencer: conditions the buttons and runs the run/pause/split FSM.
// Define STOPWATCH_LAP_EN to build the lap conditioner, SPLIT state, lap_capture and disp_hold.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_1khz,
  input  logic btn_start_stop,
  input  logic btn_clear,
  input  logic btn_lap,
  input  logic max_reached,
  output logic count_en,
  output logic cnt_clr,
  output logic lap_capture,
  output logic disp_hold,
  output logic status_led
);

  state_e r_state;
  state_e w_nextState;
  event_e w_event;
  logic   w_startStopPress;
  logic   w_clearPress;
  logic   w_lapPress;
  logic   w_maxEvent;
  logic   w_running;
  logic   w_clrNext;
  logic   w_lapNext;
  logic   r_cntClr;
  logic   r_lapCapture;

  button_conditioner #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_condStartStop (
    .i_clk(clk), .i_reset(reset), .i_tick(tick_1khz),
    .i_btn(btn_start_stop), .o_press(w_startStopPress)
  );

  button_conditioner #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_condClear (
    .i_clk(clk), .i_reset(reset), .i_tick(tick_1khz),
    .i_btn(btn_clear), .o_press(w_clearPress)
  );

`ifdef STOPWATCH_LAP_EN
  button_conditioner #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_condLap (
    .i_clk(clk), .i_reset(reset), .i_tick(tick_1khz),
    .i_btn(btn_lap), .o_press(w_lapPress)
  );
  assign w_running = (r_state == S_RUN) || (r_state == S_SPLIT);
`else
  logic w_unusedLap;
  assign w_unusedLap = btn_lap;
  assign w_lapPress  = 1'b0;
  assign w_running   = (r_state == S_RUN);
`endif

  // The terminal count only counts as an event while the counter is moving.
  assign w_maxEvent = max_reached & w_running;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cntClr     <= 1'b0;
      r_lapCapture <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_cntClr     <= w_clrNext;
      r_lapCapture <= w_lapNext;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_clrNext   = 1'b0;
    w_lapNext   = 1'b0;
    w_event     = pickEvent(w_clearPress, w_maxEvent, w_startStopPress, w_lapPress);
    case (w_event)
      EV_CLEAR: begin
        w_nextState = S_IDLE;
        w_clrNext   = 1'b1;
      end
      EV_MAX: w_nextState = S_PAUSE;
      EV_START_STOP: begin
        case (r_state)
          S_IDLE:  w_nextState = S_RUN;
          S_RUN:   w_nextState = S_PAUSE;
          S_PAUSE: if (!max_reached) w_nextState = S_RUN;
`ifdef STOPWATCH_LAP_EN
          S_SPLIT: w_nextState = S_PAUSE;
`endif
          default: w_nextState = S_IDLE;
        endcase
      end
`ifdef STOPWATCH_LAP_EN
      // Lap splits a running count and rejoins it; elsewhere it is ignored.
      EV_LAP: begin
        if (r_state == S_RUN) begin
          w_nextState = S_SPLIT;
          w_lapNext   = 1'b1;
        end else if (r_state == S_SPLIT) begin
          w_nextState = S_RUN;
        end
      end
`endif
      default: w_nextState = r_state;
    endcase
  end

  assign count_en   = w_running;
  assign status_led = w_running;
  assign cnt_clr    = r_cntClr;
`ifdef STOPWATCH_LAP_EN
  assign lap_capture = r_lapCapture;
  assign disp_hold   = (r_state == S_SPLIT);
`else
  assign lap_capture = 1'b0;
  assign disp_hold   = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DEBOUNCE_TICKS=4; lap checks follow STOPWATCH_LAP_EN.
module tb_stopwatch_ctrl;

  localparam int DT = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick = 1'b1;
  logic bSS = 1'b0;
  logic bClr = 1'b0;
  logic bLap = 1'b0;
  logic maxR = 1'b0;
  logic count_en, cnt_clr, lap_capture, disp_hold, status_led;

  int compared = 0;
  int mismatched = 0;
  int clrPulses = 0;
  int lapPulses = 0;
  int enRises = 0;
  logic enPrev = 1'b0;

  stopwatch_ctrl #(.DEBOUNCE_TICKS(DT)) dut (
    .clk(clk), .reset(reset), .tick_1khz(tick),
    .btn_start_stop(bSS), .btn_clear(bClr), .btn_lap(bLap),
    .max_reached(maxR), .count_en(count_en), .cnt_clr(cnt_clr),
    .lap_capture(lap_capture), .disp_hold(disp_hold), .status_led(status_led)
  );

  always #5 clk = ~clk;

  // Pulse outputs are tallied in clk-high cycles so a stretched pulse shows up.
  always @(negedge clk) begin
    if (cnt_clr === 1'b1) clrPulses++;
    if (lap_capture === 1'b1) lapPulses++;
    if (count_en === 1'b1 && enPrev !== 1'b1) enRises++;
    enPrev = count_en;
  end

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold one button long enough to debounce, then let the release settle.
  task automatic pressBtn(input int which, input int hold);
    if (which == 0) bSS = 1'b1; else if (which == 1) bClr = 1'b1; else bLap = 1'b1;
    waitClk(hold);
    bSS = 1'b0; bClr = 1'b0; bLap = 1'b0;
    waitClk(12);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    waitClk(3);
    compared++; if (count_en !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_count_en: got %b want 0", count_en); end
    compared++; if (cnt_clr !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_cnt_clr: got %b want 0", cnt_clr); end
    compared++; if (lap_capture !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_lap_capture: got %b want 0", lap_capture); end
    compared++; if (disp_hold !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_disp_hold: got %b want 0", disp_hold); end
    compared++; if (status_led !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_status_led: got %b want 0", status_led); end
    reset = 1'b0;
    clrPulses = 0;
    waitClk(10);
    compared++; if (count_en !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_count_en: got %b want 0", count_en); end
    compared++; if (status_led !== 1'b0) begin mismatched++; $display("[TB] FAIL idle_status_led: got %b want 0", status_led); end
    compared++; if (clrPulses !== 0) begin mismatched++; $display("[TB] FAIL idle_cnt_clr_pulses: got %0d want 0", clrPulses); end
  endtask

  task automatic test_start_stop;
    clrPulses = 0;
    bSS = 1'b1;
    waitClk(DT + 3);
    compared++; if (count_en !== 1'b0) begin mismatched++; $display("[TB] FAIL start_early_count_en: got %b want 0", count_en); end
    waitClk(1);
    compared++; if (count_en !== 1'b1) begin mismatched++; $display("[TB] FAIL start_latency_count_en: got %b want 1", count_en); end
    compared++; if (status_led !== 1'b1) begin mismatched++; $display("[TB] FAIL start_latency_status_led: got %b want 1", status_led); end
    waitClk(2);
    bSS = 1'b0;
    waitClk(12);
    compared++; if (count_en !== 1'b1) begin mismatched++; $display("[TB] FAIL start_release_count_en: got %b want 1", count_en); end
    compared++; if (clrPulses !== 0) begin mismatched++; $display("[TB] FAIL start_no_cnt_clr: got %0d want 0", clrPulses); end
  endtask

  task automatic test_bounce;
    pressBtn(1, 10);
    enRises = 0;
    bSS = 1'b1;
    waitClk(3);
    bSS = 1'b0;
    waitClk(12);
    compared++; if (count_en !== 1'b0) begin mismatched++; $display("[TB] FAIL short_pulse_count_en: got %b want 0", count_en); end
    compared++; if (enRises !== 0) begin mismatched++; $display("[TB] FAIL short_pulse_rises: got %0d want 0", enRises); end
    for (int i = 0; i < 5; i++) begin
      bSS = 1'b1;
      waitClk(3);
      bSS = 1'b0;
      waitClk(1);
    end
    bSS = 1'b1;
    waitClk(10);
    bSS = 1'b0;
    waitClk(12);
    compared++; if (count_en !== 1'b1) begin mismatched++; $display("[TB] FAIL bounce_count_en: got %b want 1", count_en); end
    compared++; if (enRises !== 1) begin mismatched++; $display("[TB] FAIL bounce_rises: got %0d want 1", enRises); end
  endtask

  task automatic test_lap;
    lapPulses = 0;
`ifdef STOPWATCH_LAP_EN
    bLap = 1'b1;
    waitClk(DT + 4);
    compared++; if (lap_capture !== 1'b1) begin mismatched++; $display("[TB] FAIL lap_capture_edge: got %b want 1", lap_capture); end
    compared++; if (disp_hold !== 1'b1) begin mismatched++; $display("[TB] FAIL lap_disp_hold: got %b want 1", disp_hold); end
    compared++; if (count_en !== 1'b1) begin mismatched++; $display("[TB] FAIL lap_count_en: got %b want 1", count_en); end
    waitClk(1);
    compared++; if (lap_capture !== 1'b0) begin mismatched++; $display("[TB] FAIL lap_capture_width: got %b want 0", lap_capture); end
    waitClk(1);
    bLap = 1'b0;
    waitClk(12);
    compared++; if (lapPulses !== 1) begin mismatched++; $display("[TB] FAIL lap_pulse_count: got %0d want 1", lapPulses); end
    pressBtn(2, 10);
    compared++; if (disp_hold !== 1'b0) begin mismatched++; $display("[TB] FAIL lap_rejoin_disp_hold: got %b want 0", disp_hold); end
    compared++; if (count_en !== 1'b1) begin mismatched++; $display("[TB] FAIL lap_rejoin_count_en: got %b want 1", count_en); end
    compared++; if (lapPulses !== 1) begin mismatched++; $display("[TB] FAIL lap_rejoin_pulses: got %0d want 1", lapPulses); end
    pressBtn(2, 10);
    compared++; if (disp_hold !== 1'b1) begin mismatched++; $display("[TB] FAIL split_again_disp_hold: got %b want 1", disp_hold); end
    pressBtn(0, 10);
    compared++; if (count_en !== 1'b0) begin mismatched++; $display("[TB] FAIL split_pause_count_en: got %b want 0", count_en); end
    compared++; if (disp_hold !== 1'b0) begin mismatched++; $display("[TB] FAIL split_pause_disp_hold: got %b want 0", disp_hold); end
    pressBtn(2, 10);
    compared++; if (lapPulses !== 2 || disp_hold !== 1'b0) begin mismatched++; $display("[TB] FAIL pause_lap_ignored: got pulses %0d hold %b want 2 0", lapPulses, disp_hold); end
    pressBtn(0, 10);
`else
    pressBtn(2, 10);
    compared++; if (lapPulses !== 0) begin mismatched++; $display("[TB] FAIL nolap_pulses: got %0d want 0", lapPulses); end
    compared++; if (disp_hold !== 1'b0) begin mismatched++; $display("[TB] FAIL nolap_disp_hold: got %b want 0", disp_hold); end
`endif
    compared++; if (count_en !== 1'b1) begin mismatched++; $display("[TB] FAIL lap_end_running: got %b want 1", count_en); end
  endtask

  task automatic test_clear_priority;
    clrPulses = 0;
    bClr = 1'b1;
    bSS = 1'b1;
    waitClk(DT + 4);
    compared++; if (cnt_clr !== 1'b1) begin mismatched++; $display("[TB] FAIL clear_pulse_edge: got %b want 1", cnt_clr); end
    compared++; if (count_en !== 1'b0) begin mismatched++; $display("[TB] FAIL clear_count_en: got %b want 0", count_en); end
    waitClk(2);
    bClr = 1'b0;
    bSS = 1'b0;
    waitClk(12);
    compared++; if (clrPulses !== 1) begin mismatched++; $display("[TB] FAIL clear_pulse_count: got %0d want 1", clrPulses); end
    compared++; if (status_led !== 1'b0) begin mismatched++; $display("[TB] FAIL clear_status_led: got %b want 0", status_led); end
  endtask

  task automatic test_max_reached;
    pressBtn(0, 10);
    compared++; if (count_en !== 1'b1) begin mismatched++; $display("[TB] FAIL max_pre_run: got %b want 1", count_en); end
    maxR = 1'b1;
    waitClk(1);
    compared++; if (count_en !== 1'b0) begin mismatched++; $display("[TB] FAIL max_stop_count_en: got %b want 0", count_en); end
    compared++; if (status_led !== 1'b0) begin mismatched++; $display("[TB] FAIL max_stop_status_led: got %b want 0", status_led); end
    pressBtn(0, 10);
    compared++; if (count_en !== 1'b0) begin mismatched++; $display("[TB] FAIL max_restart_blocked: got %b want 0", count_en); end
    clrPulses = 0;
    pressBtn(1, 10);
    compared++; if (clrPulses !== 1) begin mismatched++; $display("[TB] FAIL max_clear_pulse: got %0d want 1", clrPulses); end
    compared++; if (count_en !== 1'b0) begin mismatched++; $display("[TB] FAIL max_clear_count_en: got %b want 0", count_en); end
    maxR = 1'b0;
    pressBtn(0, 10);
    compared++; if (count_en !== 1'b1) begin mismatched++; $display("[TB] FAIL max_cleared_run: got %b want 1", count_en); end
  endtask

  task automatic test_tick_gating;
    tick = 1'b0;
    pressBtn(0, 20);
    compared++; if (count_en !== 1'b1) begin mismatched++; $display("[TB] FAIL no_tick_count_en: got %b want 1", count_en); end
    tick = 1'b1;
    waitClk(12);
    compared++; if (count_en !== 1'b1) begin mismatched++; $display("[TB] FAIL tick_resume_count_en: got %b want 1", count_en); end
  endtask

  task automatic test_reset_hold;
    bSS = 1'b1;
    reset = 1'b1;
    waitClk(2);
    compared++; if (count_en !== 1'b0) begin mismatched++; $display("[TB] FAIL midrun_reset_count_en: got %b want 0", count_en); end
    reset = 1'b0;
    waitClk(DT + 3);
    compared++; if (count_en !== 1'b0) begin mismatched++; $display("[TB] FAIL held_early_count_en: got %b want 0", count_en); end
    waitClk(1);
    compared++; if (count_en !== 1'b1) begin mismatched++; $display("[TB] FAIL held_press_count_en: got %b want 1", count_en); end
    bSS = 1'b0;
    waitClk(12);
  endtask

  initial begin
    test_reset();
    test_start_stop();
    test_bounce();
    test_lap();
    test_clear_priority();
    test_max_reached();
    test_tick_gating();
    test_reset_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
